// File: rtl/i2s_wavetable_synth.sv
// i2s_wavetable_synth: polyphonic wavetable voices, shift-and-saturate mix,
// streamed as mono-duplicated I2S with host-loadable table and voice regs.
module i2s_wavetable_synth #(
  parameter int NUM_VOICES  = 12,
  parameter int TABLE_DEPTH = 64,
  parameter int SAMPLE_W    = 24,
  parameter int PHASE_W     = 24,
  parameter int SCLK_DIV    = 8,
  parameter int MIX_SHIFT   = 2
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [31:0]                  keycode,
  input  logic [$clog2(TABLE_DEPTH):0] ram_address,
  input  logic                         ram_write,
  input  logic [31:0]                  ram_writedata,
  output logic [31:0]                  ram_readdata,
  output logic                         SCLK,
  output logic                         LRCLK,
  output logic                         Dout,
  output logic [NUM_VOICES-1:0]        active_voices,
  output logic                         clip
);
  localparam int TW = $clog2(TABLE_DEPTH);
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int DW = $clog2(SCLK_DIV);
  localparam int AW = SAMPLE_W + 5;
  localparam int IW = (PHASE_W > 24) ? PHASE_W : 24;
  localparam logic signed [AW-1:0] MAXV =
    {{6{1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{6{1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_e;

  logic [SAMPLE_W-1:0] tbl_q [TABLE_DEPTH];
  logic [SAMPLE_W-1:0] tbl_d [TABLE_DEPTH];
  logic [7:0]          key_q [NUM_VOICES];
  logic [7:0]          key_d [NUM_VOICES];
  logic [PHASE_W-1:0]  inc_q [NUM_VOICES];
  logic [PHASE_W-1:0]  inc_d [NUM_VOICES];
  logic [PHASE_W-1:0]  phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]  phase_d [NUM_VOICES];
  logic [TW-1:0]       tap_q [NUM_VOICES];
  logic [TW-1:0]       tap_d [NUM_VOICES];

  logic [NUM_VOICES-1:0] act_q, act_d, hit;
  logic [DW-1:0]         div_q, div_d;
  logic                  sclk_q, sclk_d;
  logic                  lr_q, lr_d;
  logic                  dout_q, dout_d;
  logic                  clip_q, clip_d;
  logic [5:0]            bit_q, bit_d;
  logic [SAMPLE_W-1:0]   word_q, word_d;
  logic [SAMPLE_W-1:0]   mix_q, mix_d;
  logic signed [AW-1:0]  acc_q, acc_d, shifted;
  logic [VW-1:0]         vidx_q, vidx_d;
  state_e                state_q, state_d;

  logic                  fall, frame_start;
  logic [4:0]            slot_j;
  logic [31:0]           slot_w;
  logic [TW-1:0]         a_lo;
  logic [VW-1:0]         vsel;
  logic                  v_ok;
  logic [IW-1:0]         inc_ext;
  logic [IW+7:0]         vreg_rb;

  assign a_lo = ram_address[TW-1:0];
  assign vsel = a_lo[VW-1:0];
  assign v_ok = {{(32-TW){1'b0}}, a_lo} < 32'(NUM_VOICES);
  assign inc_ext = IW'(ram_writedata[31:8]);
  assign vreg_rb = {IW'(inc_q[vsel]), key_q[vsel]};

  always_comb begin
    ram_readdata = '0;
    if (!ram_address[TW]) begin
      ram_readdata = 32'(signed'(tbl_q[a_lo]));
    end else if (v_ok) begin
      ram_readdata = vreg_rb[31:0];
    end
  end

  always_comb begin
    tbl_d = tbl_q;
    key_d = key_q;
    inc_d = inc_q;
    if (ram_write) begin
      if (!ram_address[TW]) begin
        tbl_d[a_lo] = ram_writedata[31 -: SAMPLE_W];
      end else if (v_ok) begin
        key_d[vsel] = ram_writedata[7:0];
        inc_d[vsel] = inc_ext[PHASE_W-1:0];
      end
    end
  end

  // Bit clock divider, slot counter and serializer
  always_comb begin
    div_d  = div_q + 1'b1;
    sclk_d = sclk_q;
    bit_d  = bit_q;
    lr_d   = lr_q;
    dout_d = dout_q;
    word_d = word_q;
    fall   = 1'b0;
    slot_j = '0;
    slot_w = 32'(word_q) << (32 - SAMPLE_W);
    if (div_q == DW'(SCLK_DIV - 1)) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
      fall   = sclk_q;
    end
    if (fall) begin
      bit_d  = bit_q + 6'd1;
      lr_d   = bit_d[5];
      slot_j = bit_d[4:0] - 5'd1;
      dout_d = slot_w[~slot_j];
    end
    frame_start = fall && lr_q && !lr_d;
    if (frame_start) begin
      word_d = mix_q;
    end
  end

  always_comb begin
    hit = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      hit[v] = (key_q[v] != 8'h00) &&
               ((key_q[v] == keycode[7:0])   ||
                (key_q[v] == keycode[15:8])  ||
                (key_q[v] == keycode[23:16]) ||
                (key_q[v] == keycode[31:24]));
    end
  end

  // Taps hold the pre-advance index so a fresh press starts at entry 0
  always_comb begin
    act_d   = act_q;
    phase_d = phase_q;
    tap_d   = tap_q;
    if (frame_start) begin
      act_d = hit;
      for (int v = 0; v < NUM_VOICES; v++) begin
        tap_d[v]   = phase_q[v][PHASE_W-1 -: TW];
        phase_d[v] = hit[v] ? phase_q[v] + inc_q[v] : '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    vidx_d  = vidx_q;
    acc_d   = acc_q;
    mix_d   = mix_q;
    clip_d  = 1'b0;
    shifted = acc_q >>> MIX_SHIFT;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = ACCUM;
          vidx_d  = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        if (act_q[vidx_q]) begin
          acc_d = acc_q + AW'(signed'(tbl_q[tap_q[vidx_q]]));
        end
        vidx_d = vidx_q + 1'b1;
        if (vidx_q == VW'(NUM_VOICES - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (shifted > MAXV) begin
          mix_d  = MAXV[SAMPLE_W-1:0];
          clip_d = 1'b1;
        end else if (shifted < MINV) begin
          mix_d  = MINV[SAMPLE_W-1:0];
          clip_d = 1'b1;
        end else begin
          mix_d = shifted[SAMPLE_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < TABLE_DEPTH; i++) tbl_q[i] <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v]   <= '0;
        inc_q[v]   <= '0;
        phase_q[v] <= '0;
        tap_q[v]   <= '0;
      end
      act_q   <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      lr_q    <= 1'b0;
      dout_q  <= 1'b0;
      clip_q  <= 1'b0;
      bit_q   <= '0;
      word_q  <= '0;
      mix_q   <= '0;
      acc_q   <= '0;
      vidx_q  <= '0;
      state_q <= IDLE;
    end else begin
      tbl_q   <= tbl_d;
      key_q   <= key_d;
      inc_q   <= inc_d;
      phase_q <= phase_d;
      tap_q   <= tap_d;
      act_q   <= act_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      lr_q    <= lr_d;
      dout_q  <= dout_d;
      clip_q  <= clip_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      mix_q   <= mix_d;
      acc_q   <= acc_d;
      vidx_q  <= vidx_d;
      state_q <= state_d;
    end
  end

  assign SCLK          = sclk_q;
  assign LRCLK         = lr_q;
  assign Dout          = dout_q;
  assign clip          = clip_q;
  assign active_voices = act_q;
endmodule

// File: doc/i2s_wavetable_synth.md
Name: i2s_wavetable_synth

Overview:
Polyphonic wavetable synthesizer with an integrated I2S master transmitter, all on one system clock.
- Host (Avalon-MM style) loads a shared signed wavetable and per-voice key/increment registers.
- Each voice plays while its key code is present in the 4-byte USB keycode word.
- Voices are mixed with shift-and-saturate.
- The mix is serialized as standard I2S, mono duplicated on L/R, to the audio codec.
- Successor of the fixed 12-note/8-entry player: parametrised voices, table depth and width; programmable pitch; generated SCLK/LRCLK.

Parameters:
NUM_VOICES, 12, number of voices (1..32, must be <= TABLE_DEPTH)
TABLE_DEPTH, 64, wavetable entries (power of two, >= 4)
SAMPLE_W, 24, signed sample width (8..32)
PHASE_W, 24, phase accumulator width (> log2 TABLE_DEPTH)
SCLK_DIV, 8, CLK cycles per SCLK half-period (>= 2)
MIX_SHIFT, 2, arithmetic right shift applied to the voice sum

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
keycode  in  32  four 8-bit key codes; 0x00 means no key
ram_address  in  log2(TABLE_DEPTH)+1  bit MSB=0: wavetable entry; MSB=1: voice register (low bits = voice index)
ram_write  in  1  write strobe, one CLK
ram_writedata  in  32  write data
ram_readdata  out  32  combinational read of the addressed location
SCLK  out  1  I2S bit clock
LRCLK  out  1  I2S word select (0 = left)
Dout  out  1  I2S serial data
active_voices  out  NUM_VOICES  per-voice gate, registered
clip  out  1  one-CLK pulse when the latched mix saturated

Behaviour:
- Reset values: SCLK=0, LRCLK=0, Dout=0, clip=0, active_voices=0. All table entries, voice registers, phases and the mix register are 0.
- Wavetable write: entry <= ram_writedata[31:32-SAMPLE_W], MSB-aligned. Readback is sign-extended to 32 bits.
- Voice register write: key <= wd[7:0]; inc <= wd[31:8] truncated/zero-extended to PHASE_W. Readback is {inc, key}.
- Voice address >= NUM_VOICES: writes ignored, reads return 0.
- Clocking: SCLK toggles every SCLK_DIV CLK cycles.
  - Frame = 64 SCLK periods; LRCLK toggles on the SCLK falling edge after every 32 SCLK periods.
  - Dout changes only on SCLK falling edges.
- Slot format: each 32-bit slot carries the mix MSB-first.
  - First data bit (MSB) is driven on the falling edge one SCLK after the LRCLK edge (I2S one-bit delay).
  - SAMPLE_W bits follow, then zeros to end of slot.
  - Both slots carry the same sample word, latched at frame start.
- Frame start is the LRCLK 1->0 transition. On that CLK cycle:
  1. The serializer loads the mix register.
  2. Each voice gate is evaluated: active = (key != 0) and key equals any keycode byte.
  3. Active voices add inc to phase (modulo 2^PHASE_W). Inactive voices clear phase to 0.
  4. active_voices is updated.
- Mix sequencer FSM states: IDLE -> ACCUM -> FINISH -> IDLE.
  - Enters ACCUM on the cycle after frame start.
  - Processes one voice per CLK: acc += active ? sign_extend(table[phase[PHASE_W-1 -: log2 TABLE_DEPTH]]) : 0.
  - acc width is SAMPLE_W+5 bits.
  - FINISH: shift acc arithmetically right by MIX_SHIFT, clamp to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], write the mix register; pulse clip if clamped.
  - Total NUM_VOICES+2 cycles, always completed before the next frame start.
  - Latency: a key press is heard in the frame after the one in which it is first sampled.
- Simultaneous events:
  - A table write during ACCUM: the sequencer sees the new value only if written before that voice's cycle.
  - A voice register write on the frame-start cycle: the old inc is used for that frame.
  - keycode changes between frame starts are ignored.
- Duplicate keycode bytes count once. Two voices with the same key both sound.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). Output resumes with a left slot, frame start at the first LRCLK 1->0 transition.

Test Plan:
1. Reset behaviour: hold RESET_N=0 for 5 CLK, release. Required: SCLK period = 2*SCLK_DIV CLK, LRCLK period = 64 SCLK; Dout=0 for all slots since no voice is active.
2. DC voice: table all 0x40000000 (+0x400000 at 24 bits), voice0 key 0x04 inc 0, keycode=0x00000004, MIX_SHIFT=2. Required: from the second frame both slots carry 0x100000; bit 23 appears one SCLK after the LRCLK edge; bits after 24 are 0.
3. Saturation: 12 voices, all active, table 0x7FFFFF, MIX_SHIFT=0. Required: mix = 0x7FFFFF and clip pulses once per frame. With table 0x800000, mix = 0x800000.
4. Pitch: TABLE_DEPTH=64, ramp table entry n = n<<16, inc = 2^PHASE_W/16. Required: the sequence of played indices advances by 4 per frame and wraps 60 -> 0.
5. Key release: drop key mid-frame. Required: active_voices bit clears at the next frame start; the following frame outputs 0; re-press restarts at index 0.
6. Register map: write and read back voice 3 = 0x00123416. Required: read = 0x00123416. A write to voice NUM_VOICES+1 reads back 0. Keycode bytes 0x16 in [31:24] and [7:0] give single-voice amplitude, not double.
